// File: rtl/name_table_updater_pkg.sv
// Shared constants and types for the background name table updater.
// Raster geometry, name table shape and the packed FIFO command word.
package name_table_updater_pkg;

    localparam int VGA_POSXY_BIT    = 10;
    localparam int GAME_START_LINE  = 16;
    localparam int GAME_HEIGHT      = 240;
    localparam int NT_WORDS_PER_ROW = 8;

    localparam logic [VGA_POSXY_BIT-1:0] GAME_START_POSY = VGA_POSXY_BIT'(GAME_START_LINE);
    localparam logic [VGA_POSXY_BIT-1:0] GAME_END_POSY   = VGA_POSXY_BIT'(GAME_START_LINE + GAME_HEIGHT);
    localparam logic [4:0]               NT_ROWS         = 5'd30;

    localparam int CMD_W = 41;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } nt_state_e;

    typedef struct packed {
        logic        op;
        logic [7:0]  addr;
        logic [31:0] data;
    } nt_cmd_t;

    function automatic logic in_blank_f(input logic [VGA_POSXY_BIT-1:0] pos_y);
        return (pos_y < GAME_START_POSY) || (pos_y >= GAME_END_POSY);
    endfunction

endpackage

// File: rtl/name_table_updater_sync_fifo.sv
// Single-clock FIFO with occupancy level; read data is the current head entry.
// Pushes are ignored when full and pops when empty.
module name_table_updater_sync_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == (AW+1)'(DEPTH));
    assign empty     = (level_r == (AW+1)'(0));
    assign level     = level_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and level bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/name_table_updater.sv
// Buffers CPU tile-update commands and commits them to the name table RAM
// only while the raster is outside the game window.
module name_table_updater
    import name_table_updater_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int NT_WORDS   = 240
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [VGA_POSXY_BIT-1:0]     vgaPosY,
    input  logic                         cmdValid,
    output logic                         cmdReady,
    input  logic                         cmdOp,
    input  logic [7:0]                   cmdAddr,
    input  logic [31:0]                  cmdData,
    input  logic                         clrErr,
    output logic                         nameTableWrEn,
    output logic [7:0]                   nameTableWrAddr,
    output logic [31:0]                  nameTableWrData,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifoLevel,
    output logic                         dropErr
);

    localparam logic [7:0] NT_WORDS_W = 8'(NT_WORDS);

    logic [VGA_POSXY_BIT-1:0] pos_y_r;
    logic                     in_blank_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     load_s;
    logic                     drop_s;
    logic [CMD_W-1:0]         fifo_rd_s;
    nt_cmd_t                  push_cmd_s;
    nt_cmd_t                  head_s;
    nt_state_e                state_r;
    nt_state_e                state_s;
    logic [2:0]               k_r;
    logic [2:0]               k_s;
    logic [7:0]               cmd_addr_r;
    logic [31:0]              cmd_data_r;
    logic                     wr_en_r;
    logic                     wr_en_s;
    logic [7:0]               wr_addr_r;
    logic [7:0]               wr_addr_s;
    logic [31:0]              wr_data_r;
    logic [31:0]              wr_data_s;
    logic                     drop_err_r;

    assign in_blank_s = in_blank_f(pos_y_r);
    assign push_s     = cmdValid && !fifo_full_s;
    assign push_cmd_s = '{op: cmdOp, addr: cmdAddr, data: cmdData};
    assign head_s     = nt_cmd_t'(fifo_rd_s);

    name_table_updater_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .pop_data  (fifo_rd_s),
        .level     (fifoLevel),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next state and write strobe; writes are only ever issued in blank
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        pop_s     = 1'b0;
        load_s    = 1'b0;
        drop_s    = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        case (state_r)
            ST_IDLE: begin
                if (in_blank_s && !fifo_empty_s) begin
                    pop_s  = 1'b1;
                    load_s = 1'b1;
                    k_s    = 3'd0;
                    if (!head_s.op) begin
                        if (head_s.addr < NT_WORDS_W) begin
                            state_s = ST_WRITE;
                        end else begin
                            drop_s = 1'b1;
                        end
                    end else begin
                        if (head_s.addr[7:3] < NT_ROWS) begin
                            state_s = ST_FILL;
                        end else begin
                            drop_s = 1'b1;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (in_blank_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cmd_addr_r;
                    wr_data_s = cmd_data_r;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_FILL: begin
                // Pauses (holding k) across the visible window, resumes next blank
                if (in_blank_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = {cmd_addr_r[7:3], k_r};
                    wr_data_s = {4{cmd_data_r[7:0]}};
                    k_s       = k_r + 3'd1;
                    if (k_r == 3'd7) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Raster line sample, FSM state and registered write port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pos_y_r   <= '0;
            state_r   <= ST_IDLE;
            k_r       <= 3'd0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= 8'd0;
            wr_data_r <= 32'd0;
        end else begin
            pos_y_r   <= vgaPosY;
            state_r   <= state_s;
            k_r       <= k_s;
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
        end
    end

    // Command latched at pop time
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_addr_r <= 8'd0;
            cmd_data_r <= 32'd0;
        end else if (load_s) begin
            cmd_addr_r <= head_s.addr;
            cmd_data_r <= head_s.data;
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_err_r <= 1'b0;
        end else if (drop_s) begin
            drop_err_r <= 1'b1;
        end else if (clrErr) begin
            drop_err_r <= 1'b0;
        end
    end

    assign cmdReady        = !fifo_full_s;
    assign busy            = !fifo_empty_s || (state_r != ST_IDLE);
    assign dropErr         = drop_err_r;
    assign nameTableWrEn   = wr_en_r;
    assign nameTableWrAddr = wr_addr_r;
    assign nameTableWrData = wr_data_r;

endmodule

// File: tb/tb_name_table_updater.sv
// Directed plus randomized bench for name_table_updater; expected RAM writes
// come from a queue-based model of the command semantics.
module tb_name_table_updater;
    import name_table_updater_pkg::*;

    localparam int Y_START = GAME_START_LINE;
    localparam int Y_END   = GAME_START_LINE + 240;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [VGA_POSXY_BIT-1:0] vgaPosY;
    logic                     cmdValid;
    logic                     cmdReady;
    logic                     cmdOp;
    logic [7:0]               cmdAddr;
    logic [31:0]              cmdData;
    logic                     clrErr;
    logic                     nameTableWrEn;
    logic [7:0]               nameTableWrAddr;
    logic [31:0]              nameTableWrData;
    logic                     busy;
    logic [3:0]               fifoLevel;
    logic                     dropErr;

    int          total_cnt   = 0;
    int          pass_cnt    = 0;
    int          writes_seen = 0;
    logic [39:0] exp_q[$];
    bit          drop_m      = 1'b0;
    logic [2:0]  vis_h       = 3'b000;

    always #5 clk = ~clk;

    name_table_updater dut (
        .clk             (clk),
        .rstn            (rstn),
        .vgaPosY         (vgaPosY),
        .cmdValid        (cmdValid),
        .cmdReady        (cmdReady),
        .cmdOp           (cmdOp),
        .cmdAddr         (cmdAddr),
        .cmdData         (cmdData),
        .clrErr          (clrErr),
        .nameTableWrEn   (nameTableWrEn),
        .nameTableWrAddr (nameTableWrAddr),
        .nameTableWrData (nameTableWrData),
        .busy            (busy),
        .fifoLevel       (fifoLevel),
        .dropErr         (dropErr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit visible_f(input int y);
        return (y >= Y_START) && (y < Y_END);
    endfunction

    // Reference: the ordered list of RAM writes a command must produce
    function automatic void model_cmd(input bit op, input logic [7:0] addr, input logic [31:0] data);
        int row;
        row = int'(addr) / 8;
        if (!op) begin
            if (int'(addr) < 240) exp_q.push_back({addr, data});
            else drop_m = 1'b1;
        end else begin
            if (row < 30) begin
                for (int k = 0; k < 8; k++) begin
                    exp_q.push_back({8'(row * 8 + k), {4{data[7:0]}}});
                end
            end else begin
                drop_m = 1'b1;
            end
        end
    endfunction

    // Write monitor: order/content against the model, never late into the visible window
    always @(negedge clk) begin
        logic [2:0]  v;
        logic [39:0] e;
        v = {vis_h[1:0], visible_f(int'(vgaPosY))};
        vis_h = v;
        if (rstn && nameTableWrEn) begin
            chk("write_in_visible", 64'(&v), 64'd0);
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_addr_data", {24'd0, nameTableWrAddr, nameTableWrData}, {24'd0, e});
            end
            writes_seen++;
        end
    end

    task automatic push(input bit op, input logic [7:0] addr, input logic [31:0] data);
        int i;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdAddr  = addr;
        cmdData  = data;
        for (i = 0; i < 300 && !cmdReady; i++) begin
            @(posedge clk); #1;
        end
        chk("push_ready", 64'(cmdReady), 64'd1);
        @(posedge clk); #1;
        cmdValid = 1'b0;
        model_cmd(op, addr, data);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && !busy) break;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int run;
        int base;
        bit vis;

        rstn     = 1'b0;
        vgaPosY  = '0;
        cmdValid = 1'b0;
        cmdOp    = 1'b0;
        cmdAddr  = 8'd0;
        cmdData  = 32'd0;
        clrErr   = 1'b0;
        #12;
        chk("rst_ready", 64'(cmdReady), 64'd1);
        chk("rst_wren", 64'(nameTableWrEn), 64'd0);
        chk("rst_addr", 64'(nameTableWrAddr), 64'd0);
        chk("rst_data", 64'(nameTableWrData), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_level", 64'(fifoLevel), 64'd0);
        chk("rst_drop", 64'(dropErr), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single word write, latency and busy return
        push(1'b0, 8'h05, 32'h11223344);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            lat++;
            if (nameTableWrEn) break;
        end
        chk("word_latency", 64'(lat), 64'd3);
        repeat (3) @(negedge clk);
        #1;
        chk("busy_after_word", 64'(busy), 64'd0);

        // Uninterrupted row fill: 8 back-to-back writes
        push(1'b1, {5'd3, 3'(($urandom % 8))}, {24'($urandom), 8'h07});
        for (int i = 0; i < 10 && !nameTableWrEn; i++) begin
            @(negedge clk); #1;
        end
        run = 0;
        while (nameTableWrEn && run < 12) begin
            run++;
            @(negedge clk); #1;
        end
        chk("fill_run_len", 64'(run), 64'd8);
        wait_drain("fill_drain");

        // Row fill cut by the visible window after 3 words, finished next blank
        base = writes_seen;
        push(1'b1, 8'h18, 32'h00000007);
        for (int i = 0; i < 20 && writes_seen < base + 2; i++) begin
            @(negedge clk); #1;
        end
        vgaPosY = VGA_POSXY_BIT'(Y_START);
        repeat (20) @(negedge clk);
        #1;
        chk("fill_paused_count", 64'(writes_seen - base), 64'd3);
        chk("fill_paused_busy", 64'(busy), 64'd1);
        vgaPosY = VGA_POSXY_BIT'(Y_END);
        wait_drain("fill_resume_drain");
        chk("fill_total", 64'(writes_seen - base), 64'd8);

        // Nine pushes during visible lines: eight fit, ninth held off
        vgaPosY = VGA_POSXY_BIT'(Y_END - 1);
        repeat (3) @(posedge clk);
        #1;
        base = writes_seen;
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 8'($urandom_range(0, 239)), $urandom);
        end
        chk("full_level", 64'(fifoLevel), 64'd8);
        chk("full_ready", 64'(cmdReady), 64'd0);
        cmdValid = 1'b1;
        cmdOp    = 1'b0;
        cmdAddr  = 8'd239;
        cmdData  = $urandom;
        repeat (5) @(posedge clk);
        #1;
        chk("ninth_held_level", 64'(fifoLevel), 64'd8);
        chk("no_write_visible", 64'(writes_seen - base), 64'd0);
        vgaPosY = VGA_POSXY_BIT'(Y_START - 1);
        for (int i = 0; i < 20 && !cmdReady; i++) begin
            @(posedge clk); #1;
        end
        chk("ninth_accept", 64'(cmdReady), 64'd1);
        @(posedge clk); #1;
        cmdValid = 1'b0;
        model_cmd(1'b0, cmdAddr, cmdData);
        wait_drain("full_drain");
        chk("full_count", 64'(writes_seen - base), 64'd9);

        // Out-of-range drops, clear, and drop winning over clear
        base = writes_seen;
        push(1'b0, 8'hF5, $urandom);
        push(1'b1, {5'd31, 3'(($urandom % 8))}, $urandom);
        repeat (10) @(posedge clk);
        #1;
        chk("drop_set", 64'(dropErr), 64'd1);
        chk("drop_no_write", 64'(writes_seen - base), 64'd0);
        clrErr = 1'b1;
        @(posedge clk); #1;
        clrErr = 1'b0;
        chk("drop_cleared", 64'(dropErr), 64'd0);
        push(1'b0, 8'hF5, $urandom);
        clrErr = 1'b1;
        @(posedge clk); #1;
        clrErr = 1'b0;
        @(posedge clk); #1;
        chk("drop_beats_clear", 64'(dropErr), 64'd1);
        clrErr = 1'b1;
        @(posedge clk); #1;
        clrErr = 1'b0;
        drop_m = 1'b0;

        // Randomized traffic across blank/visible switches, boundary raster lines
        vis = 1'b0;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                vis = !vis;
                case ($urandom_range(0, 2))
                    0:       vgaPosY = VGA_POSXY_BIT'(vis ? Y_START : Y_START - 1);
                    1:       vgaPosY = VGA_POSXY_BIT'(vis ? Y_END - 1 : Y_END);
                    default: vgaPosY = VGA_POSXY_BIT'(vis ? Y_START + 100 : 0);
                endcase
            end
            if ($urandom_range(0, 1) == 1 && cmdReady) begin
                cmdValid = 1'b1;
                cmdOp    = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) cmdAddr = 8'($urandom_range(240, 255));
                else                          cmdAddr = 8'($urandom_range(0, 239));
                cmdData = $urandom;
                @(posedge clk); #1;
                cmdValid = 1'b0;
                model_cmd(cmdOp, cmdAddr, cmdData);
            end else begin
                @(posedge clk); #1;
            end
        end
        vgaPosY = VGA_POSXY_BIT'(0);
        wait_drain("random_drain");
        chk("random_drop", 64'(dropErr), 64'(drop_m));
        chk("random_level", 64'(fifoLevel), 64'd0);
        chk("random_ready", 64'(cmdReady), 64'd1);

        // Reset in the middle of a row fill
        base = writes_seen;
        push(1'b1, {5'd5, 3'd0}, $urandom);
        for (int i = 0; i < 20 && writes_seen < base + 2; i++) begin
            @(negedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        chk("mid_rst_wren", 64'(nameTableWrEn), 64'd0);
        chk("mid_rst_addr", 64'(nameTableWrAddr), 64'd0);
        chk("mid_rst_data", 64'(nameTableWrData), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(cmdReady), 64'd1);
        exp_q.delete();
        base = writes_seen;
        repeat (2) @(negedge clk);
        #1;
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("post_rst_no_write", 64'(writes_seen - base), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/name_table_updater.md
# name_table_updater

Upstream writer for the background name table RAM. Accepts CPU tile-update commands on a valid/ready interface and buffers them in an 8-entry FIFO. Commits them to the name table write port only while the raster is outside the game window, so the background tile fetcher on the read port never sees a half-updated frame. Supports single-word writes (4 tile indices) and whole-row fills for scrolling-row refresh.

## Interface
Parameters:
- FIFO_DEPTH, 8: command FIFO entries; power of two.
- NT_WORDS, 240: name table words (30 rows × 8 words, 4 tiles/word).

Ports:
- clk  in  1  system clock; the only clock.
- rstn  in  1  asynchronous active-low reset.
- vgaPosY  in  `VGA_POSXY_BIT  current raster line from VGA_driver.
- cmdValid  in  1  command present.
- cmdReady  out  1  FIFO can accept; equals not-full.
- cmdOp  in  1  0 = word write, 1 = row fill.
- cmdAddr  in  8  word index {row[4:0], word[2:0]}; for row fill only row[4:0] is used.
- cmdData  in  32  word data, tile 0 in [31:24]; for row fill only [7:0] is used.
- clrErr  in  1  clears dropErr.
- nameTableWrEn  out  1  RAM write strobe.
- nameTableWrAddr  out  8  RAM word address.
- nameTableWrData  out  32  RAM write data.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- fifoLevel  out  4  entries held, 0..8.
- dropErr  out  1  sticky: a command was discarded.

## Operation
- inBlank = (vgaPosY < `GAME_START_POSY) or (vgaPosY ≥ `GAME_START_POSY + 240). Compute it from vgaPosY registered once in clk.
- FSM states:
  - IDLE: if inBlank and FIFO non-empty, pop the head.
    - Word write: if addr < 240, go to WRITE; otherwise drop it, set dropErr, stay IDLE.
    - Row fill: if row < 30, go to FILL with word counter k = 0; otherwise drop it and set dropErr.
  - WRITE: assert WrEn for one cycle with addr/data, then return to IDLE.
  - FILL: while inBlank, write {row, k} with data {4{byte}}, then k++. After k = 7 is written, return to IDLE. While not inBlank, hold k and write nothing; resume at the next blank.
- A row fill is never split across a visible frame boundary except by this pause. Any words already written stay written.
- Only one RAM write per cycle. No write is ever issued while inBlank = 0.
- dropErr: set has priority over clrErr when both occur in the same cycle.
- Out-of-range row fill (row ≥ 30) is dropped, like an out-of-range word address.

## Timing
- Reset values: cmdReady 1, nameTableWrEn 0, nameTableWrAddr 0, nameTableWrData 0, busy 0, fifoLevel 0, dropErr 0. FSM goes to IDLE. FIFO pointers are cleared and in-flight commands are lost.
- Push happens on a cycle with cmdValid && cmdReady. When the FIFO is full, cmdReady is 0 and no push occurs.
- Push and pop in the same cycle: level is unchanged. Pop on an empty FIFO never occurs.
- Latency, push to WrEn: at least 3 cycles when in blank and the FIFO is empty (FIFO write, pop/decode in IDLE, WRITE).
- Throughput:
  - Word writes: 1 write per 2 cycles.
  - Row fill: 8 consecutive cycles of WrEn when uninterrupted.
- Write outputs are registered. WrAddr and WrData are valid only in cycles where WrEn = 1. Between writes they hold their last value.
- The inBlank edge takes effect with 1 cycle of delay from vgaPosY (registered). The visible window therefore must start at least 2 clk after the vgaPosY change, which holds because clk is faster than the pixel clock.

## Structure
- Shared constants live in define.v: `GAME_START_POSY, `VGA_POSXY_BIT, and a new `NT_ROWS (30) and `NT_WORDS_PER_ROW (8).
- One sub-module, syncFifo: parameterised width (41 = op + addr + data) and depth, with level output, full and empty.

## Test plan
- In blank, push word write addr 0x05, data 0x11223344 -> a single WrEn with addr 0x05, data 0x11223344 after ≤3 cycles; busy then returns to 0.
- In blank, push row fill cmdAddr row 3, data 0x..0007 -> 8 consecutive WrEn cycles, addr 0x18..0x1F, data 0x07070707.
- Row fill started 3 cycles before the visible window begins -> 3 writes (0x18..0x1A), none during visible lines, remaining 0x1B..0x1F in the next blank.
- During visible lines, push 9 commands -> cmdReady drops after the 8th, fifoLevel = 8, the 9th is held off; all 8 drain in the next blank.
- Push word write addr 0xF5 (≥240) and row fill row 31 -> no WrEn for either, dropErr = 1; clrErr clears it; simultaneous drop and clrErr leaves it 1.
- Assert rstn low mid row fill -> all outputs return to reset values immediately, and no further writes occur after release.
